// File: rtl/breakout_input_conditioner.sv
// N-channel button conditioner: synchroniser, counter debouncer, registered press/release
// strobes and an optional hold-to-repeat strobe per channel, between board pins and game logic.
module breakout_input_conditioner #(
  parameter int              N_CH            = 3,
  parameter int              DEBOUNCE_CYCLES = 10000,
  parameter int              SYNC_STAGES     = 2,
  parameter int              REPEAT_DELAY    = 25000000,
  parameter int              REPEAT_PERIOD   = 5000000,
  parameter logic [N_CH-1:0] REPEAT_MASK     = 3'b011,
  parameter logic [N_CH-1:0] INVERT_MASK     = 3'b000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic [N_CH-1:0] btn_repeat
);

  localparam int CW   = $clog2(DEBOUNCE_CYCLES);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX);

  localparam logic [CW-1:0] CNT_LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_REPEAT
  } rpt_state_e;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   level_q;
    logic [CW-1:0]          cnt_q;
    logic                   settle;
    logic                   rise;
    logic                   fall;
    logic                   press_q;
    logic                   release_q;
    logic                   repeat_q;
    logic                   repeat_d;
    rpt_state_e             state_q;
    rpt_state_e             state_d;
    logic [RW-1:0]          rcnt_q;
    logic [RW-1:0]          rcnt_d;

    assign s      = sync_q[SYNC_STAGES-1];
    assign settle = (s != level_q) && (cnt_q == CNT_LAST);
    assign rise   = settle && s;
    assign fall   = settle && !s;

    // NOTE: every flop here, the synchroniser included, is cleared by the async reset so that
    // a button held through reset is seen as a fresh press afterwards, never as a release.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync_q <= '0;
      end else begin
        // NOTE: non-blocking assignments make every stage sample the pre-edge value.
        sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in[i] ^ INVERT_MASK[i]};
      end
    end

    // Any sample agreeing with the current level restarts the stability count.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        level_q   <= 1'b0;
        cnt_q     <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        if (s == level_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
          level_q <= s;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        press_q   <= rise;
        release_q <= fall;
        repeat_q  <= repeat_d;
      end
    end

    always_comb begin
      // NOTE: defaults first so no path through the case leaves a variable unassigned (no latch).
      state_d  = state_q;
      rcnt_d   = rcnt_q;
      repeat_d = 1'b0;
      case (state_q)
        RPT_IDLE: begin
          if (rise) begin
            repeat_d = 1'b1;
            rcnt_d   = '0;
            if (REPEAT_MASK[i]) state_d = RPT_DELAY;
          end
        end
        RPT_DELAY, RPT_REPEAT: begin
          // Release takes priority over a terminal count landing on the same edge.
          if (fall) begin
            state_d = RPT_IDLE;
            rcnt_d  = '0;
          end else if (rcnt_q == ((state_q == RPT_DELAY) ? DELAY_LAST : PERIOD_LAST)) begin
            repeat_d = 1'b1;
            rcnt_d   = '0;
            state_d  = RPT_REPEAT;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        default: begin
          state_d = RPT_IDLE;
          rcnt_d  = '0;
        end
      endcase
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q <= RPT_IDLE;
        rcnt_q  <= '0;
      end else begin
        state_q <= state_d;
        rcnt_q  <= rcnt_d;
      end
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
    assign btn_repeat[i]  = repeat_q;
  end

endmodule

// File: tb/tb_breakout_input_conditioner.sv
// Directed bench for breakout_input_conditioner: expected strobe events are queued as stimulus
// is driven and matched against the DUT's strobes as they appear.
module tb_breakout_input_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] btn_in;
  logic [2:0] btn_level;
  logic [2:0] btn_press;
  logic [2:0] btn_release;
  logic [2:0] btn_repeat;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct packed {
    int         cyc;
    logic [2:0] press;
    logic [2:0] rel;
    logic [2:0] rep;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_ev;

  breakout_input_conditioner #(
    .N_CH           (3),
    .DEBOUNCE_CYCLES(16),
    .SYNC_STAGES    (2),
    .REPEAT_DELAY   (40),
    .REPEAT_PERIOD  (10),
    .REPEAT_MASK    (3'b011),
    .INVERT_MASK    (3'b000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_repeat (btn_repeat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // Strobes appear just after edge cyc; compare each against the oldest queued expectation.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
        mon_ev = exp_q.pop_front();
        check("missed_event", 64'(cyc), 64'(mon_ev.cyc));
      end
      if ((btn_press | btn_release | btn_repeat) != 3'b000) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {btn_press, btn_release, btn_repeat}, 9'd0);
        end else begin
          mon_ev = exp_q.pop_front();
          check("ev_cycle", 64'(cyc), 64'(mon_ev.cyc));
          check("ev_strobes", {btn_press, btn_release, btn_repeat},
                {mon_ev.press, mon_ev.rel, mon_ev.rep});
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
    #1;
  endtask

  task automatic drain(input string tag, input int budget);
    int t0 = cyc;
    while (exp_q.size() != 0 && cyc < t0 + budget) begin
      @(negedge clk);
      #1;
    end
    check(tag, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, p, r, ef;

    reset  = 1'b0;
    btn_in = 3'b000;
    repeat (3) @(negedge clk);
    #1;
    check("rst_level", 64'(btn_level), 64'd0);
    check("rst_strobes", {btn_press, btn_release, btn_repeat}, 9'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;

    // 1. Clean press on ch0, then a release well before the first auto-repeat.
    btn_in[0] = 1'b1;
    e0 = cyc + 1;
    p  = e0 + 17;
    exp_q.push_back('{p, 3'b001, 3'b000, 3'b001});
    wait_cyc(p - 1);
    check("t1_level_before", 64'(btn_level), 64'd0);
    wait_cyc(p);
    check("t1_level_after", 64'(btn_level), 64'b001);
    btn_in[0] = 1'b0;
    r = cyc + 18;
    exp_q.push_back('{r, 3'b000, 3'b001, 3'b000});
    wait_cyc(r - 1);
    check("t1_rel_level_before", 64'(btn_level), 64'b001);
    wait_cyc(r);
    check("t1_rel_level_after", 64'(btn_level), 64'd0);
    wait_cyc(p + 60);
    drain("t1_drain", 5);

    // 2. Bounce on ch2: five toggles five cycles apart, ending high.
    ef = 0;
    for (int k = 0; k < 5; k++) begin
      btn_in[2] = ~btn_in[2];
      ef = cyc + 1;
      if (k < 4) begin
        repeat (5) @(negedge clk);
        #1;
        check("t2_bounce_level", 64'(btn_level), 64'd0);
      end
    end
    exp_q.push_back('{ef + 17, 3'b100, 3'b000, 3'b100});
    wait_cyc(ef + 16);
    check("t2_level_before", 64'(btn_level), 64'd0);
    wait_cyc(ef + 17);
    check("t2_level_after", 64'(btn_level), 64'b100);
    drain("t2_press_drain", 5);
    btn_in[2] = 1'b0;
    exp_q.push_back('{cyc + 18, 3'b000, 3'b100, 3'b000});
    drain("t2_release_drain", 40);

    // 3. 15-cycle glitch on ch1 must be swallowed.
    btn_in[1] = 1'b1;
    e0 = cyc + 1;
    repeat (15) @(negedge clk);
    #1;
    btn_in[1] = 1'b0;
    wait_cyc(e0 + 17);
    check("t3_level_mid", 64'(btn_level), 64'd0);
    wait_cyc(e0 + 40);
    check("t3_level_end", 64'(btn_level), 64'd0);
    drain("t3_drain", 1);

    // 4/5. Hold ch0 and ch2; ch0 auto-repeats, ch2 does not. Release ch0 on a terminal count.
    btn_in = 3'b101;
    p = cyc + 18;
    exp_q.push_back('{p, 3'b101, 3'b000, 3'b101});
    for (int m = 0; m < 7; m++) exp_q.push_back('{p + 40 + 10 * m, 3'b000, 3'b000, 3'b001});
    wait_cyc(p + 92);
    btn_in[0] = 1'b0;
    exp_q.push_back('{p + 110, 3'b000, 3'b001, 3'b000});
    wait_cyc(p + 100);
    check("t4_level_held", 64'(btn_level), 64'b101);
    wait_cyc(p + 110);
    check("t5_level_released", 64'(btn_level), 64'b100);
    wait_cyc(p + 140);
    drain("t5_drain", 1);
    btn_in[2] = 1'b0;
    exp_q.push_back('{cyc + 18, 3'b000, 3'b100, 3'b000});
    drain("t4_ch2_release_drain", 40);

    // 6. Reset in the middle of the repeat delay with ch0 held.
    btn_in[0] = 1'b1;
    p = cyc + 18;
    exp_q.push_back('{p, 3'b001, 3'b000, 3'b001});
    wait_cyc(p + 10);
    check("t6_level_held", 64'(btn_level), 64'b001);
    #2;
    reset = 1'b0;
    #1;
    check("t6_rst_level", 64'(btn_level), 64'd0);
    check("t6_rst_strobes", {btn_press, btn_release, btn_repeat}, 9'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    p = cyc + 18;
    exp_q.push_back('{p, 3'b001, 3'b000, 3'b001});
    #1;
    wait_cyc(p - 1);
    check("t6_level_before", 64'(btn_level), 64'd0);
    wait_cyc(p);
    check("t6_level_after", 64'(btn_level), 64'b001);
    wait_cyc(p + 20);
    drain("t6_drain", 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
